fare_collector: RTL
===================

Name: fare_collector

Overview:
- Upstream stage of the turnstile controller.
- Accepts denominated coin events from the coin sensor, accumulates credit until the fare is met, then emits a single-cycle coin pulse that drives the turnstile's coin input.
- Returns change on overpayment, and returns the full credit on cancel or inactivity timeout.

Parameters:
- FARE, 100: fare in cents; must be at least 1.
- VAL_W, 8: coin value width.
- CREDIT_W, 10: credit and change width; must hold FARE + 2^VAL_W - 2.
- TIMEOUT_CYC, 1000: idle cycles in COLLECT before an automatic refund; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- coin_in_valid  in  1  single-cycle coin event from the sensor.
- coin_in_value  in  VAL_W  coin value in cents; qualified by coin_in_valid.
- cancel  in  1  passenger cancel request.
- coin_in_ready  out  1  high when a coin event will be accepted.
- coin  out  1  one-cycle pulse to the turnstile coin input.
- credit  out  CREDIT_W  current accumulated credit.
- change_valid  out  1  one-cycle pulse; change_amount is valid.
- change_amount  out  CREDIT_W  amount to return.
- timeout_flag  out  1  one-cycle pulse when a refund is caused by timeout.
- coin_reject  out  1  one-cycle pulse; a coin arrived while not ready.

Behaviour:
- Reset, asynchronous on rst=0:
  - State IDLE; credit=0, coin=0, change_valid=0, change_amount=0, timeout_flag=0, coin_reject=0, idle timer=0.
  - Any pending credit is discarded; no change is emitted.
- All outputs are registered. coin_in_ready is high in IDLE and COLLECT only.
- States:
  - IDLE:
    - coin_in_valid with value 0 is ignored.
    - Value v>0 sets credit=v and clears the timer.
    - Next state is GRANT if v>=FARE, otherwise COLLECT.
    - cancel is ignored in IDLE.
  - COLLECT:
    - An accepted coin computes sum=credit+v at CREDIT_W+1 bits (no overflow), sets credit=sum and clears the timer.
    - If sum>=FARE, next state is GRANT.
    - With no coin, the timer increments.
    - When the timer reaches TIMEOUT_CYC-1 with no coin that cycle, go to REFUND and set timeout_flag for the REFUND cycle.
    - cancel goes to REFUND.
  - GRANT, exactly one cycle:
    - coin=1.
    - change_amount=credit-FARE; change_valid=1 only if that amount is nonzero.
    - credit=0 at the end of the cycle; next state IDLE.
  - REFUND, exactly one cycle:
    - change_valid=1, change_amount=credit.
    - credit=0; next state IDLE.
- Latency: a completing coin sampled at edge N gives coin=1 from edge N to edge N+1. The turnstile samples the pulse at N+1.
- Simultaneous events in COLLECT:
  - cancel and a coin together: the coin is added first. If sum>=FARE, GRANT wins. Otherwise REFUND of the full sum.
  - A coin arriving on the timeout cycle: the coin wins and the timer clears.
- A coin in GRANT or REFUND is not credited; coin_reject pulses in the following cycle.
- change_valid deasserts after one cycle; change_amount holds its last value.

Decomposition:
- Shared package fare_pkg:
  - State enum: IDLE, COLLECT, GRANT, REFUND.
  - Default FARE and width constants, shared with the turnstile testbench.
- One sub-module, fare_timeout_timer: clear/enable counter with a terminal-count output at TIMEOUT_CYC-1, on the same clock and asynchronous reset.

Test Plan:
1. Reset:
   - Stimulus: hold rst=0 for 2 cycles, then release.
   - Required: coin=0, credit=0, change_valid=0, coin_in_ready=1.
2. Exact fare (FARE=100):
   - Stimulus: coins 25, 25, 50 on separate cycles.
   - Required: credit goes 25, then 50; coin pulses exactly one cycle after the 50 is sampled; change_valid stays 0; credit returns to 0.
3. Overpay:
   - Stimulus: coins 75, then 50.
   - Required: coin pulse with change_valid=1 and change_amount=25 in the same cycle; the following coin is accepted in IDLE.
4. Cancel:
   - Stimulus: coin 40, then cancel.
   - Required: change_valid=1 with change_amount=40; no coin pulse; timeout_flag=0.
   - Stimulus: cancel together with a coin of 30.
   - Required: change_amount=70.
5. Timeout (bench uses TIMEOUT_CYC=16):
   - Stimulus: coin 10, then 16 idle cycles.
   - Required: timeout_flag and change_valid pulse with amount 10.
   - Stimulus: a coin on cycle 15.
   - Required: no refund; the timer restarts.
6. Reset mid-operation and reject:
   - Stimulus: rst=0 while credit=60.
   - Required: credit=0 immediately (asynchronous), with no change pulse.
   - Stimulus: a coin during the GRANT cycle.
   - Required: coin_reject pulses; credit stays 0.

Source files
------------

// File: rtl/fare_pkg.sv
// Fare collector shared definitions.
// Holds the FSM state encoding and the default fare/width constants that the
// collector and the turnstile bench agree on.
package fare_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    GRANT   = 2'd2,
    REFUND  = 2'd3
  } fare_state_e;

  localparam int FARE_DEF        = 100;
  localparam int VAL_W_DEF       = 8;
  localparam int CREDIT_W_DEF    = 10;
  localparam int TIMEOUT_CYC_DEF = 1000;

endpackage

// File: rtl/fare_timeout_timer.sv
// Idle timer for the fare collector.
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   i_clr     synchronous clear (wins over i_en)
//   i_en      count enable
//   o_tc      terminal count, high while the count equals TIMEOUT_CYC-1
module fare_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  // The collector leaves COLLECT on terminal count, so the count never wraps.
  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/fare_collector.sv
// Fare collector: accumulates coin credit, pulses the turnstile coin input once
// the fare is met, returns change on overpay and full credit on cancel/timeout.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   coin_in_valid/coin_in_value   coin event from the sensor
//   cancel                        passenger cancel
//   coin_in_ready                 coin events are accepted (IDLE/COLLECT)
//   coin                          one-cycle grant pulse to the turnstile
//   credit                        accumulated credit
//   change_valid/change_amount    change/refund pulse and amount (amount holds)
//   timeout_flag                  refund was caused by inactivity
//   coin_reject                   a coin arrived in GRANT/REFUND (one cycle late)
// All outputs are registered: the output process computes next-cycle values
// from the next state, and a single register stage drives the ports.
module fare_collector
  import fare_pkg::*;
#(
  parameter int FARE        = FARE_DEF,
  parameter int VAL_W       = VAL_W_DEF,
  parameter int CREDIT_W    = CREDIT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in_valid,
  input  logic [VAL_W-1:0]    coin_in_value,
  input  logic                cancel,
  output logic                coin_in_ready,
  output logic                coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                timeout_flag,
  output logic                coin_reject
);

  localparam logic [CREDIT_W:0] L_FARE = (CREDIT_W+1)'(FARE);

  fare_state_e         r_state, w_state_nx;
  logic                w_accept, w_meets, w_tc, w_busy;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_credit_nx, w_chg_nx;
  logic                w_coin_nx, w_cv_nx, w_to_nx, w_ready_nx, w_rej_nx;

  assign w_busy   = (r_state == GRANT) || (r_state == REFUND);
  // Zero-value events carry no credit and do not count as activity.
  assign w_accept = coin_in_valid && (coin_in_value != '0) && !w_busy;
  // IDLE starts from zero credit; one extra bit keeps the sum exact.
  assign w_sum    = (r_state == IDLE ? '0 : (CREDIT_W+1)'(credit))
                  + (CREDIT_W+1)'(coin_in_value);
  assign w_meets  = (w_sum >= L_FARE);

  fare_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept || (r_state != COLLECT)),
    .i_en  (r_state == COLLECT),
    .o_tc  (w_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nx;
  end

  // Next state: in COLLECT a coin is added before cancel/timeout are looked at.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nx = w_meets ? GRANT : COLLECT;
      COLLECT: begin
        if (w_accept && w_meets)            w_state_nx = GRANT;
        else if (cancel || (!w_accept && w_tc)) w_state_nx = REFUND;
      end
      GRANT:   w_state_nx = IDLE;
      REFUND:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Next output values
  always_comb begin
    w_credit_nx = credit;
    if (w_accept)    w_credit_nx = CREDIT_W'(w_sum);
    else if (w_busy) w_credit_nx = '0;

    w_coin_nx  = (w_state_nx == GRANT);
    w_ready_nx = (w_state_nx == IDLE) || (w_state_nx == COLLECT);
    w_rej_nx   = coin_in_valid && w_busy;
    w_to_nx    = (r_state == COLLECT) && !w_accept && !cancel && w_tc;

    w_cv_nx  = 1'b0;
    w_chg_nx = change_amount;
    if (w_state_nx == GRANT) begin
      w_chg_nx = CREDIT_W'(w_sum - L_FARE);
      w_cv_nx  = (w_sum != L_FARE);
    end else if (w_state_nx == REFUND) begin
      w_chg_nx = w_credit_nx;
      w_cv_nx  = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit        <= '0;
      coin          <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      timeout_flag  <= 1'b0;
      coin_reject   <= 1'b0;
      coin_in_ready <= 1'b1;
    end else begin
      credit        <= w_credit_nx;
      coin          <= w_coin_nx;
      change_valid  <= w_cv_nx;
      change_amount <= w_chg_nx;
      timeout_flag  <= w_to_nx;
      coin_reject   <= w_rej_nx;
      coin_in_ready <= w_ready_nx;
    end
  end

endmodule
